// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-fetch path.
//   H_ACTIVE / V_ACTIVE : default visible raster size
//   FRAME_PIXELS        : pixels fetched per frame
//   rgb332_t            : 8-bit pixel, R[7:5] G[4:2] B[1:0]
//   fetch_state_t       : fetch FSM states
package vga_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef logic [7:0] rgb332_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/vga_fwft_fifo.sv
// First-word-fall-through pixel FIFO.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : empty the FIFO (wins over push/pop)
//   push_i  : write data_i
//   data_i  : pixel to write
//   pop_i   : discard the head entry
//   head_o  : head entry, 0 when empty
//   level_o : current occupancy (0..DEPTH)
module vga_fwft_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  rgb332_t                  data_i,
  input  logic                     pop_i,
  output rgb332_t                  head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_C = LVL_W'(DEPTH);

  rgb332_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               do_push;
  logic               do_pop;

  // Guard against overflow/underflow even though the caller never asks for it.
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != DEPTH_C) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: head_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

endmodule

// File: rtl/vga_pixel_fetcher.sv
// Raster-order pixel fetcher feeding the VGA driver.
// Reads pixels from frame memory over a req/ack handshake into a FWFT FIFO,
// presents the head pixel on colors and pops it on need_pixel.
//   clk25MHz   : pixel clock
//   rst        : asynchronous active-low reset
//   en         : enable pops and new requests
//   vsync      : rising edge realigns fetch address and flushes the FIFO
//   need_pixel : driver consumes the head pixel this cycle
//   colors     : head pixel (0 when FIFO empty)
//   mem_req    : read request, held until mem_ack
//   mem_addr   : read address, stable while mem_req is high
//   mem_ack    : one-cycle acknowledge, mem_data valid
//   mem_data   : read data
//   underflow  : sticky, pop attempted on empty FIFO; cleared by vsync rise
//   fifo_level : FIFO occupancy
module vga_pixel_fetcher
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                          clk25MHz,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          vsync,
  input  logic                          need_pixel,
  output logic [7:0]                    colors,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  input  logic [7:0]                    mem_data,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FRAME   = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [LVL_W:0]    DEPTH_C = (LVL_W + 1)'(FIFO_DEPTH);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               underflow_q, underflow_d;
  logic               vsync_d_q;

  logic               vsync_rise;
  logic               push;
  logic               pop;
  logic               outstanding;
  logic               credit;
  logic [LVL_W-1:0]   level;
  rgb332_t            head;

  assign vsync_rise  = vsync && !vsync_d_q;
  assign outstanding = (state_q == REQ);
  assign credit      = ({1'b0, level} + {{LVL_W{1'b0}}, outstanding}) < DEPTH_C;
  assign pop         = en && need_pixel && (level != '0) && !vsync_rise;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    addr_d      = addr_q;
    push        = 1'b0;
    underflow_d = underflow_q;

    if (vsync_rise) begin
      underflow_d = 1'b0;
    end else if (en && need_pixel && (level == '0)) begin
      underflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (vsync_rise) begin
          state_d = IDLE;
        end else if (pix_cnt_q == FRAME) begin
          state_d = DONE;
        end else if (en && credit) begin
          state_d = REQ;
          addr_d  = BASE + pix_cnt_q;
        end
      end
      REQ: begin
        if (vsync_rise) begin
          // Data acked in the realign cycle belongs to the old frame.
          state_d = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          push      = 1'b1;
          pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ack) state_d = IDLE;
      end
      DONE: begin
        if (vsync_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (vsync_rise) begin
      pix_cnt_d = '0;
      // The old-frame request is still outstanding in DRAIN, so its address
      // is held until the ack; the next request is issued from BASE anyway.
      if (state_d != DRAIN) addr_d = BASE;
    end
  end

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      pix_cnt_q   <= '0;
      addr_q      <= BASE;
      underflow_q <= 1'b0;
      vsync_d_q   <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      addr_q      <= addr_d;
      underflow_q <= underflow_d;
      vsync_d_q   <= vsync;
    end
  end

  vga_fwft_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk25MHz),
    .rst_ni  (rst),
    .flush_i (vsync_rise),
    .push_i  (push),
    .data_i  (mem_data),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (level)
  );

  assign mem_req    = (state_q == REQ) || (state_q == DRAIN);
  assign mem_addr   = addr_q;
  assign colors     = head;
  assign underflow  = underflow_q;
  assign fifo_level = level;

endmodule
